gf64_pow_engine: RTL and testbench



---
 rtl/gf64_tower_pkg.sv | 107 ++++++++++
 rtl/gf64_pow_engine_if.sv | 24 ++
 rtl/gf64_tower_mul.sv | 10 +
 rtl/gf64_pow_engine.sv | 109 ++++++++++
 tb/tb_gf64_pow_engine.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/gf64_tower_pkg.sv
// GF(2^6) tower arithmetic: GF(4) in normal basis {w, w^2}, extended by y^3 = w.
// Polynomial basis uses modulus x^6 + x + 1; basis-change matrices are derived at elaboration.
package gf64_tower_pkg;

   typedef logic [1:0] gf4_t;
   typedef logic [5:0] gf64_t;
   // Column i holds the image of unit vector i.
   typedef gf64_t [5:0] basis_t;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   // One in the tower is w + w^2 in the constant coefficient.
   localparam gf64_t ONE_T = 6'h03;

   function automatic gf4_t gf4_mul(input gf4_t a, input gf4_t b);
      logic t;
      t = (a[1] ^ a[0]) & (b[1] ^ b[0]);
      return {t ^ (a[1] & b[1]), t ^ (a[0] & b[0])};
   endfunction

   function automatic gf4_t gf4_sq(input gf4_t a);
      return {a[0], a[1]};
   endfunction

   // Multiply by w: the cubic reduction constant, y^3 = w.
   function automatic gf4_t gf4_mul_w(input gf4_t a);
      return {a[0], a[1] ^ a[0]};
   endfunction

   function automatic gf64_t gf64_mul(input gf64_t a, input gf64_t b);
      gf4_t d0, d1, d2, d3, d4;
      d0 = gf4_mul(a[1:0], b[1:0]);
      d1 = gf4_mul(a[3:2], b[1:0]) ^ gf4_mul(a[1:0], b[3:2]);
      d2 = gf4_mul(a[5:4], b[1:0]) ^ gf4_mul(a[3:2], b[3:2]) ^ gf4_mul(a[1:0], b[5:4]);
      d3 = gf4_mul(a[5:4], b[3:2]) ^ gf4_mul(a[3:2], b[5:4]);
      d4 = gf4_mul(a[5:4], b[5:4]);
      return {d2, d1 ^ gf4_mul_w(d4), d0 ^ gf4_mul_w(d3)};
   endfunction

   // Squaring is linear: y^4 folds to w*y.
   function automatic gf64_t gf64_sq(input gf64_t a);
      return {gf4_sq(a[3:2]), gf4_mul_w(gf4_sq(a[5:4])), gf4_sq(a[1:0])};
   endfunction

   function automatic gf64_t mat_apply(input basis_t m, input gf64_t x);
      gf64_t r;
      r = '0;
      for (int i = 0; i < 6; i++) begin
         if (x[i]) r = r ^ m[i];
      end
      return r;
   endfunction

   // Tower image of the polynomial-basis generator: a root of x^6 + x + 1.
   function automatic gf64_t find_root();
      gf64_t g, g2, g3, g6, r;
      logic  found;
      r     = ONE_T;
      found = 1'b0;
      for (int c = 0; c < 64; c++) begin
         g  = gf64_t'(c);
         g2 = gf64_mul(g, g);
         g3 = gf64_mul(g2, g);
         g6 = gf64_mul(g3, g3);
         if (!found && ((g6 ^ g ^ ONE_T) == 6'h00)) begin
            r     = g;
            found = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic basis_t iso_basis();
      basis_t m;
      gf64_t  root, p;
      root = find_root();
      p    = ONE_T;
      for (int i = 0; i < 6; i++) begin
         m[i] = p;
         p    = gf64_mul(p, root);
      end
      return m;
   endfunction

   function automatic basis_t inv_basis(input basis_t fwd);
      basis_t m;
      m = '0;
      for (int j = 0; j < 6; j++) begin
         for (int y = 0; y < 64; y++) begin
            if (mat_apply(fwd, gf64_t'(y)) == (gf64_t'(1) << j)) m[j] = gf64_t'(y);
         end
      end
      return m;
   endfunction

   localparam basis_t ISO_M     = iso_basis();
   localparam basis_t INV_ISO_M = inv_basis(ISO_M);

   function automatic gf64_t iso(input gf64_t x);
      return mat_apply(ISO_M, x);
   endfunction

   function automatic gf64_t inv_iso(input gf64_t x);
      return mat_apply(INV_ISO_M, x);
   endfunction

endpackage

// File: rtl/gf64_pow_engine_if.sv
// Operand/result handshake bundle for the GF(2^6) power engine.
interface gf64_pow_engine_if #(
   parameter int unsigned N_LANES = 1,
   parameter int unsigned EXP_W   = 6
);
   logic                   in_valid;
   logic                   in_ready;
   logic [6*N_LANES-1:0]   in_x;
   logic [EXP_W-1:0]       in_e;
   logic                   out_valid;
   logic                   out_ready;
   logic [6*N_LANES-1:0]   out_y;
   logic                   busy;

   modport master (
      output in_valid, in_x, in_e, out_ready,
      input  in_ready, out_valid, out_y, busy
   );

   modport slave (
      input  in_valid, in_x, in_e, out_ready,
      output in_ready, out_valid, out_y, busy
   );
endinterface

// File: rtl/gf64_tower_mul.sv
// Combinational multiplier in the GF(4)^3 tower representation; one per lane.
module gf64_tower_mul
   import gf64_tower_pkg::*;
(
   input  gf64_t a_i,
   input  gf64_t b_i,
   output gf64_t p_o
);
   assign p_o = gf64_mul(a_i, b_i);
endmodule

// File: rtl/gf64_pow_engine.sv
// Iterative y = x^e over GF(2^6): left-to-right square-and-multiply in the tower field,
// one exponent bit per cycle, shared exponent across lanes.
module gf64_pow_engine
   import gf64_tower_pkg::*;
#(
   parameter int unsigned N_LANES = 1,
   parameter int unsigned EXP_W   = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   gf64_pow_engine_if.slave   bus
);

   localparam int unsigned CNT_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

   state_e                 state_q, state_d;
   gf64_t [N_LANES-1:0]    acc_q, acc_d;
   gf64_t [N_LANES-1:0]    base_q, base_d;
   gf64_t [N_LANES-1:0]    out_y_q, out_y_d;
   gf64_t [N_LANES-1:0]    prod;
   logic  [EXP_W-1:0]      exp_q, exp_d;
   logic  [CNT_W-1:0]      cnt_q, cnt_d;
   logic                   accept;
   logic                   last;
   logic                   bit_set;

   assign accept  = (state_q == StIdle) && bus.in_valid;
   assign last    = (state_q == StRun) && (cnt_q == '0);
   assign bit_set = exp_q[cnt_q];

   for (genvar g = 0; g < N_LANES; g++) begin : g_lane
      gf64_t sq_acc, mult;
      assign sq_acc = gf64_sq(acc_q[g]);
      assign mult   = bit_set ? base_q[g] : ONE_T;

      gf64_tower_mul u_mul (
         .a_i (sq_acc),
         .b_i (mult),
         .p_o (prod[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.in_valid) state_d = StRun;
         StRun:   if (cnt_q == '0) state_d = StDone;
         StDone:  if (bus.out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // in_ready is gated by rst_n so it reads low throughout reset.
   always_comb begin
      bus.in_ready  = rst_n && (state_q == StIdle);
      bus.out_valid = (state_q == StDone);
      bus.busy      = (state_q == StRun) || (state_q == StDone);
      bus.out_y     = out_y_q;
   end

   always_comb begin
      acc_d   = acc_q;
      base_d  = base_q;
      exp_d   = exp_q;
      cnt_d   = cnt_q;
      out_y_d = out_y_q;
      if (accept) begin
         for (int i = 0; i < N_LANES; i++) begin
            base_d[i] = iso(bus.in_x[6*i +: 6]);
            acc_d[i]  = ONE_T;
         end
         exp_d = bus.in_e;
         cnt_d = CNT_W'(EXP_W - 1);
      end else if (state_q == StRun) begin
         acc_d = prod;
         cnt_d = cnt_q - 1'b1;
         if (last) begin
            for (int i = 0; i < N_LANES; i++) begin
               out_y_d[i] = inv_iso(prod[i]);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         base_q  <= '0;
         exp_q   <= '0;
         cnt_q   <= '0;
         out_y_q <= '0;
      end else begin
         acc_q   <= acc_d;
         base_q  <= base_d;
         exp_q   <= exp_d;
         cnt_q   <= cnt_d;
         out_y_q <= out_y_d;
      end
   end

endmodule

// File: tb/tb_gf64_pow_engine.sv
// Self-checking bench for gf64_pow_engine with four lanes against a polynomial-basis model.
module tb_gf64_pow_engine;

   localparam int NL = 4;
   localparam int XW = 6 * NL;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   gf64_pow_engine_if #(.N_LANES(NL), .EXP_W(6)) bus ();

   gf64_pow_engine #(.N_LANES(NL), .EXP_W(6)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      string          name;
      logic [XW-1:0]  x;
      logic [5:0]     e;
      logic [XW-1:0]  y;
   } vec_t;

   vec_t vt[9];

   // Polynomial basis, modulus x^6 + x + 1.
   function automatic logic [5:0] pmul(input logic [5:0] a, input logic [5:0] b);
      logic [5:0] r, s;
      r = 6'h00;
      s = a;
      for (int i = 0; i < 6; i++) begin
         if (b[i]) r = r ^ s;
         s = {s[4:0], 1'b0} ^ (s[5] ? 6'h03 : 6'h00);
      end
      return r;
   endfunction

   function automatic logic [5:0] ppow(input logic [5:0] x, input logic [5:0] e);
      logic [5:0] r;
      r = 6'h01;
      for (int k = 0; k < int'(e); k++) r = pmul(r, x);
      return r;
   endfunction

   function automatic logic [XW-1:0] lanes_pow(input logic [XW-1:0] x, input logic [5:0] e);
      logic [XW-1:0] y;
      for (int j = 0; j < NL; j++) y[6*j +: 6] = ppow(x[6*j +: 6], e);
      return y;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic xfer(input logic [XW-1:0] x, input logic [5:0] e, output logic [XW-1:0] y);
      int n;
      bus.in_x     = x;
      bus.in_e     = e;
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("run_flags", {30'd0, bus.in_ready, bus.busy}, 32'd1);
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", 32'(n), 32'd6);
      y = bus.out_y;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("idle_after", {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'd4);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [XW-1:0] x, y, y2, exp_y;
      logic [5:0]    e;
      logic          stable;
      int            n;

      vt[0] = '{"e1_2a",     {6'h3F, 6'h15, 6'h01, 6'h2A}, 6'd1,  {6'h3F, 6'h15, 6'h01, 6'h2A}};
      vt[1] = '{"e0",        {6'h00, 6'h3F, 6'h00, 6'h3F}, 6'd0,  {6'h01, 6'h01, 6'h01, 6'h01}};
      vt[2] = '{"e63",       {6'h3F, 6'h15, 6'h01, 6'h00}, 6'd63, {6'h01, 6'h01, 6'h01, 6'h00}};
      vt[3] = '{"alpha_e6",  {6'h02, 6'h08, 6'h04, 6'h02}, 6'd6,  {6'h03, 6'h0F, 6'h05, 6'h03}};
      vt[4] = '{"alpha_e7",  {6'h02, 6'h02, 6'h02, 6'h02}, 6'd7,  {6'h06, 6'h06, 6'h06, 6'h06}};
      vt[5] = '{"zero_e5",   {XW{1'b0}},                   6'd5,  {XW{1'b0}}};
      vt[6] = '{"alpha_inv", {6'h02, 6'h02, 6'h02, 6'h02}, 6'd62, {6'h21, 6'h21, 6'h21, 6'h21}};
      vt[7] = '{"lanes_e41", {6'h3F, 6'h15, 6'h01, 6'h00}, 6'd41, {XW{1'b0}}};
      vt[7].y = lanes_pow(vt[7].x, 6'd41);
      vt[8] = '{"e20_05",    {6'h05, 6'h05, 6'h05, 6'h05}, 6'd20, {XW{1'b0}}};
      vt[8].y = lanes_pow(vt[8].x, 6'd20);

      bus.in_valid  = 1'b0;
      bus.in_x      = '0;
      bus.in_e      = '0;
      bus.out_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_flags", {30'd0, bus.out_valid, bus.busy}, 32'd0);
      chk("rst_out_y", 32'(bus.out_y), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_ready", 32'(bus.in_ready), 32'd1);

      for (int i = 0; i < 9; i++) begin
         xfer(vt[i].x, vt[i].e, y);
         chk(vt[i].name, 32'(y), 32'(vt[i].y));
      end

      // Full sweeps: identity, e=63, and e=20/e=41 round trip.
      for (int t = 0; t < 16; t++) begin
         for (int j = 0; j < NL; j++) begin
            x[6*j +: 6]     = 6'(4 * t + j);
            exp_y[6*j +: 6] = (x[6*j +: 6] == 6'h00) ? 6'h00 : 6'h01;
         end
         xfer(x, 6'd1, y);
         chk("sweep_e1", 32'(y), 32'(x));
         xfer(x, 6'd63, y);
         chk("sweep_e63", 32'(y), 32'(exp_y));
         xfer(x, 6'd20, y);
         chk("sweep_e20", 32'(y), 32'(lanes_pow(x, 6'd20)));
         xfer(y, 6'd41, y2);
         chk("round_trip", 32'(y2), 32'(x));
      end

      for (int t = 0; t < 30; t++) begin
         x = XW'($urandom);
         e = 6'($urandom_range(0, 63));
         xfer(x, e, y);
         chk("random", 32'(y), 32'(lanes_pow(x, e)));
      end

      // Backpressure: result held, in_valid ignored while DONE.
      x = XW'($urandom);
      bus.in_x     = x;
      bus.in_e     = 6'd20;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_latency", 32'(n), 32'd6);
      y = bus.out_y;
      chk("bp_model", 32'(y), 32'(lanes_pow(x, 6'd20)));
      stable = 1'b1;
      for (int k = 0; k < 10; k++) begin
         bus.in_valid = k[0];
         bus.in_x     = XW'($urandom);
         @(posedge clk); #1;
         if (bus.out_y !== y || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) stable = 1'b0;
      end
      chk("bp_hold", 32'(stable), 32'd1);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("bp_release", {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'd4);

      // Reset three cycles into RUN aborts the operation.
      bus.in_x     = XW'($urandom);
      bus.in_e     = 6'd20;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_flags", {29'd0, bus.out_valid, bus.busy, bus.in_ready}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      x = {XW'($urandom)};
      x[5:0] = 6'h05;
      xfer(x, 6'd20, y);
      chk("post_reset_e20", 32'(y), 32'(lanes_pow(x, 6'd20)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
